// File: rtl/wb_sel_pipe_if.sv
// Write-back stage bus: MEM-stage handshake and operands, load return data,
// and the register-file write port with the load-timeout error pulse.
interface wb_sel_pipe_if #(
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_src;
    logic          in_we;
    logic [AW-1:0] in_rd;
    logic [1:0]    in_ld_size;
    logic          in_ld_sign;
    logic [1:0]    in_boff;
    logic [31:0]   alu_out;
    logic [31:0]   opr2;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic          err_timeout;

    // Write-back stage side
    modport slave (
        input  in_valid, in_src, in_we, in_rd, in_ld_size, in_ld_sign, in_boff,
        input  alu_out, opr2, mem_rdata, mem_rvalid,
        output in_ready, rf_we, rf_waddr, rf_wdata, err_timeout
    );

    // Pipeline / memory / register-file side
    modport master (
        output in_valid, in_src, in_we, in_rd, in_ld_size, in_ld_sign, in_boff,
        output alu_out, opr2, mem_rdata, mem_rvalid,
        input  in_ready, rf_we, rf_waddr, rf_wdata, err_timeout
    );
endinterface

// File: rtl/wb_sel_pipe.sv
// Registered write-back stage. Selects ALU, load or operand-2 data for the
// register-file write port with one cycle of latency. Loads whose data is not
// present at accept time park in WAIT_MEM until mem_rvalid or a timeout.
module wb_sel_pipe #(
    parameter int AW       = 5,
    parameter int TIMEOUT  = 16,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_sel_pipe_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_MEM
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_OPR2 = 2'd3
    } src_e;

    state_e        state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [AW-1:0] lat_rd_q,   lat_rd_d;
    logic          lat_we_q,   lat_we_d;
    logic [1:0]    lat_size_q, lat_size_d;
    logic          lat_sign_q, lat_sign_d;
    logic [1:0]    lat_boff_q, lat_boff_d;
    logic          rf_we_q,    rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          err_q,      err_d;

    // Byte/half/word extraction from the load data with optional sign extension
    function automatic logic [31:0] ld_extract(
        input logic [1:0]  size,
        input logic        sign,
        input logic [1:0]  boff,
        input logic [31:0] data
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = data[{boff, 3'b000} +: 8];
        h = data[{boff[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = {{24{sign & b[7]}}, b};
            2'd1:    r = {{16{sign & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    // Register 0 is hard-wired when ZERO_REG is set
    function automatic logic wr_ok(input logic [AW-1:0] rd);
        return !((ZERO_REG != 0) && (rd == '0));
    endfunction

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.err_timeout = err_q;

    // Next-state, wait counter, latched load fields and write-port values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_rd_d   = lat_rd_q;
        lat_we_d   = lat_we_q;
        lat_size_d = lat_size_q;
        lat_sign_d = lat_sign_q;
        lat_boff_d = lat_boff_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_src == SRC_MEM) begin
                        if (bus.mem_rvalid) begin
                            rf_we_d    = bus.in_we && wr_ok(bus.in_rd);
                            rf_waddr_d = bus.in_rd;
                            rf_wdata_d = ld_extract(bus.in_ld_size, bus.in_ld_sign,
                                                    bus.in_boff, bus.mem_rdata);
                        end else begin
                            lat_rd_d   = bus.in_rd;
                            lat_we_d   = bus.in_we;
                            lat_size_d = bus.in_ld_size;
                            lat_sign_d = bus.in_ld_sign;
                            lat_boff_d = bus.in_boff;
                            cnt_d      = CW'(1);
                            state_d    = ST_WAIT_MEM;
                        end
                    end else begin
                        rf_we_d    = bus.in_we && (bus.in_src != SRC_NONE) && wr_ok(bus.in_rd);
                        rf_waddr_d = bus.in_rd;
                        rf_wdata_d = (bus.in_src == SRC_OPR2) ? bus.opr2 : bus.alu_out;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    rf_we_d    = lat_we_q && wr_ok(lat_rd_q);
                    rf_waddr_d = lat_rd_q;
                    rf_wdata_d = ld_extract(lat_size_q, lat_sign_q, lat_boff_q, bus.mem_rdata);
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_rd_q   <= '0;
            lat_we_q   <= 1'b0;
            lat_size_q <= '0;
            lat_sign_q <= 1'b0;
            lat_boff_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_rd_q   <= lat_rd_d;
            lat_we_q   <= lat_we_d;
            lat_size_q <= lat_size_d;
            lat_sign_q <= lat_sign_d;
            lat_boff_q <= lat_boff_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Testbench for wb_sel_pipe: two instances (ZERO_REG=1 and ZERO_REG=0) share
// one stimulus stream; expectations come from a transaction-level model.
module tb_wb_sel_pipe;

    localparam int AW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [1:0]    in_src;
    logic          in_we;
    logic [AW-1:0] in_rd;
    logic [1:0]    in_ld_size;
    logic          in_ld_sign;
    logic [1:0]    in_boff;
    logic [31:0]   alu_out;
    logic [31:0]   opr2;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_sel_pipe_if #(.AW(AW)) bus_z ();
    wb_sel_pipe_if #(.AW(AW)) bus_n ();

    assign bus_z.in_valid   = in_valid;
    assign bus_z.in_src     = in_src;
    assign bus_z.in_we      = in_we;
    assign bus_z.in_rd      = in_rd;
    assign bus_z.in_ld_size = in_ld_size;
    assign bus_z.in_ld_sign = in_ld_sign;
    assign bus_z.in_boff    = in_boff;
    assign bus_z.alu_out    = alu_out;
    assign bus_z.opr2       = opr2;
    assign bus_z.mem_rdata  = mem_rdata;
    assign bus_z.mem_rvalid = mem_rvalid;

    assign bus_n.in_valid   = in_valid;
    assign bus_n.in_src     = in_src;
    assign bus_n.in_we      = in_we;
    assign bus_n.in_rd      = in_rd;
    assign bus_n.in_ld_size = in_ld_size;
    assign bus_n.in_ld_sign = in_ld_sign;
    assign bus_n.in_boff    = in_boff;
    assign bus_n.alu_out    = alu_out;
    assign bus_n.opr2       = opr2;
    assign bus_n.mem_rdata  = mem_rdata;
    assign bus_n.mem_rvalid = mem_rvalid;

    wb_sel_pipe #(.AW(AW), .TIMEOUT(TO), .ZERO_REG(1)) u_dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_z)
    );

    wb_sel_pipe #(.AW(AW), .TIMEOUT(TO), .ZERO_REG(0)) u_dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    // Reference load extraction using shifts and masks on the whole word
    function automatic logic [31:0] ref_extract(input logic [1:0] size, input bit sign,
                                                input logic [1:0] boff, input logic [31:0] d);
        int unsigned v;
        if (size >= 2'd2) return d;
        if (size == 2'd0) begin
            v = (d >> (8 * int'(boff))) & 32'hFF;
            if (sign && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else begin
            v = (d >> (16 * (int'(boff) / 2))) & 32'hFFFF;
            if (sign && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic bit exp_we(input logic [1:0] src, input bit we,
                                  input logic [AW-1:0] rd, input bit zr);
        return we && (src != 2'd0) && !(zr && rd == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_fields();
        in_src     = 2'($urandom);
        in_we      = 1'($urandom);
        in_rd      = AW'($urandom);
        in_ld_size = 2'($urandom);
        in_ld_sign = 1'($urandom);
        in_boff    = 2'($urandom);
        alu_out    = $urandom;
        opr2       = $urandom;
        mem_rdata  = $urandom;
    endtask

    task automatic check_outs(input string tag, input bit we_z, input bit we_n, input bit chk_data,
                              input logic [AW-1:0] addr, input logic [31:0] data,
                              input bit err, input bit rdy);
        chk({tag, ".we_z"}, 32'(bus_z.rf_we), 32'(we_z));
        chk({tag, ".we_n"}, 32'(bus_n.rf_we), 32'(we_n));
        if (chk_data) begin
            chk({tag, ".addr_z"}, 32'(bus_z.rf_waddr), 32'(addr));
            chk({tag, ".addr_n"}, 32'(bus_n.rf_waddr), 32'(addr));
            chk({tag, ".data_z"}, bus_z.rf_wdata, data);
            chk({tag, ".data_n"}, bus_n.rf_wdata, data);
        end
        chk({tag, ".err_z"}, 32'(bus_z.err_timeout), 32'(err));
        chk({tag, ".err_n"}, 32'(bus_n.err_timeout), 32'(err));
        chk({tag, ".rdy_z"}, 32'(bus_z.in_ready), 32'(rdy));
        chk({tag, ".rdy_n"}, 32'(bus_n.in_ready), 32'(rdy));
    endtask

    // Idle cycles with stray mem_rvalid pulses that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b0;
            junk_fields();
            mem_rvalid = 1'($urandom);
            tick();
            mem_rvalid = 1'b0;
            check_outs("idle", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        end
    endtask

    // One instruction. delay: 0 = load data in the accept cycle, k in 1..TO =
    // data on the k-th wait cycle, anything above TO = no data (timeout).
    task automatic run_txn(input string tag, input logic [1:0] src, input bit we,
                           input logic [AW-1:0] rd, input logic [1:0] size, input bit sign,
                           input logic [1:0] boff, input logic [31:0] alu, input logic [31:0] op,
                           input logic [31:0] mdata, input int delay);
        logic [31:0] ed;
        chk({tag, ".pre_rdy_z"}, 32'(bus_z.in_ready), 32'd1);
        chk({tag, ".pre_rdy_n"}, 32'(bus_n.in_ready), 32'd1);
        in_valid   = 1'b1;
        in_src     = src;
        in_we      = we;
        in_rd      = rd;
        in_ld_size = size;
        in_ld_sign = sign;
        in_boff    = boff;
        alu_out    = alu;
        opr2       = op;
        mem_rvalid = (src == 2'd2) && (delay == 0);
        mem_rdata  = mem_rvalid ? mdata : $urandom;
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        junk_fields();
        if (src != 2'd2 || delay == 0) begin
            ed = (src == 2'd2) ? ref_extract(size, sign, boff, mdata) :
                 (src == 2'd3) ? op : alu;
            check_outs(tag, exp_we(src, we, rd, 1'b1), exp_we(src, we, rd, 1'b0),
                       src != 2'd0, rd, ed, 1'b0, 1'b1);
            return;
        end
        for (int k = 1; k <= TO; k++) begin
            chk({tag, ".wait_rdy_z"}, 32'(bus_z.in_ready), 32'd0);
            chk({tag, ".wait_rdy_n"}, 32'(bus_n.in_ready), 32'd0);
            in_valid = 1'($urandom);
            if (k == delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mdata;
            end
            tick();
            in_valid   = 1'b0;
            mem_rvalid = 1'b0;
            junk_fields();
            if (k == delay) begin
                check_outs(tag, exp_we(src, we, rd, 1'b1), exp_we(src, we, rd, 1'b0), 1'b1,
                           rd, ref_extract(size, sign, boff, mdata), 1'b0, 1'b1);
                return;
            end else if (k == TO) begin
                check_outs({tag, ".tmo"}, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
                return;
            end else begin
                chk({tag, ".wait_we_z"}, 32'(bus_z.rf_we), 32'd0);
                chk({tag, ".wait_we_n"}, 32'(bus_n.rf_we), 32'd0);
                chk({tag, ".wait_err_z"}, 32'(bus_z.err_timeout), 32'd0);
                chk({tag, ".wait_err_n"}, 32'(bus_n.err_timeout), 32'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    r_src;
        bit            r_we;
        logic [AW-1:0] r_rd;
        int            r_delay;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        junk_fields();
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        idle(1);

        run_txn("t1_alu", 2'd1, 1'b1, 5'd3, 2'd0, 1'b0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
        chk("t1_lit", bus_z.rf_wdata, 32'h1234_5678);
        idle(1);

        run_txn("t2_sbyte", 2'd2, 1'b1, 5'd7, 2'd0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h0080_0000, 0);
        chk("t2_lit", bus_z.rf_wdata, 32'hFFFF_FF80);

        run_txn("t3_half", 2'd2, 1'b1, 5'd9, 2'd1, 1'b0, 2'd2, 32'h0, 32'h0, 32'hBEEF_0000, 3);
        chk("t3_lit", bus_z.rf_wdata, 32'h0000_BEEF);
        idle(1);

        run_txn("t4_tmo", 2'd2, 1'b1, 5'd4, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, TO + 1);
        idle(1);

        run_txn("t4b_last", 2'd2, 1'b1, 5'd12, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0, 32'hCAFE_F00D, TO);
        idle(1);

        run_txn("t5_zero", 2'd3, 1'b1, 5'd0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_00A5, 32'h0, 0);
        chk("t5_lit_n", bus_n.rf_wdata, 32'h0000_00A5);
        idle(1);

        // Reset while a load is pending: no write and no error afterwards
        in_valid   = 1'b1;
        in_src     = 2'd2;
        in_we      = 1'b1;
        in_rd      = 5'd5;
        mem_rvalid = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_wait_rdy", 32'(bus_z.in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check_outs("t6_rst", 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        idle(TO + 3);

        for (int t = 0; t < 150; t++) begin
            r_src   = 2'($urandom);
            r_we    = ($urandom_range(0, 3) != 0);
            r_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            r_delay = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, TO + 1);
            run_txn("rnd", r_src, r_we, r_rd, 2'($urandom), 1'($urandom), 2'($urandom),
                    $urandom, $urandom, $urandom, r_delay);
            idle($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
